// File: rtl/mul_sched_pkg.sv
// mul_sched_pkg: shared state encoding and index-width helper for the multiply job scheduler.
package mul_sched_pkg;

   typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, RESP, FLUSH, RECOVER} state_e;

   function automatic int idw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting at ptr and wrapping modulo NUM_REQ.
module rr_arbiter
   import mul_sched_pkg::*;
#(
   parameter int  NUM_REQ = 4,
   localparam int IDW     = idw(NUM_REQ)
) (
   input  logic [IDW-1:0]     ptr,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDW-1:0]     idx
);

   // Walk from the farthest offset back to ptr so the nearest requester overrides.
   always_comb begin
      grant = '0;
      idx   = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req[(int'(ptr) + i) % NUM_REQ]) begin
            grant                              = '0;
            grant[(int'(ptr) + i) % NUM_REQ]   = 1'b1;
            idx                                = IDW'((int'(ptr) + i) % NUM_REQ);
         end
      end
   end

endmodule

// File: rtl/mul_job_scheduler.sv
// mul_job_scheduler: round-robin job scheduler driving a shared multiply engine.
// Defining MUL_SCHED_TIMEOUT_EN adds a watchdog that ends a stuck WAIT with rsp_err=1.
module mul_job_scheduler
   import mul_sched_pkg::*;
#(
   parameter int  BIT_WIDTH      = 16,
   parameter int  NUM_REQ        = 4,
   parameter int  TIMEOUT_CYCLES = 500,
   localparam int IDW            = idw(NUM_REQ)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_REQ-1:0]             req_valid,
   output logic [NUM_REQ-1:0]             req_ready,
   input  logic [NUM_REQ*BIT_WIDTH-1:0]   req_a,
   input  logic [NUM_REQ*BIT_WIDTH-1:0]   req_b,
   output logic                           rsp_valid,
   input  logic                           rsp_ready,
   output logic [IDW-1:0]                 rsp_id,
   output logic [BIT_WIDTH-1:0]           rsp_result,
   output logic                           rsp_err,
   output logic                           eng_start,
   output logic                           eng_rst_n,
   output logic [BIT_WIDTH-1:0]           eng_operand_a,
   output logic [BIT_WIDTH-1:0]           eng_operand_b,
   input  logic [BIT_WIDTH-1:0]           eng_result,
   input  logic                           eng_done,
   output logic                           busy
);

   if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
      $error("mul_job_scheduler: NUM_REQ must be 2..8 and TIMEOUT_CYCLES positive");
   end

   state_e               state_q, state_d;
   logic [IDW-1:0]       ptr_q, ptr_d, id_q, id_d, gidx;
   logic [NUM_REQ-1:0]   grant;
   logic [BIT_WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, res_q, res_d;
   logic                 flush_q, flush_d;
`ifdef MUL_SCHED_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;
   assign rsp_err = err_q;
`else
   assign rsp_err = 1'b0;
`endif

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .ptr   (ptr_q),
      .req   (req_valid),
      .grant (grant),
      .idx   (gidx)
   );

   // Reset is asynchronous, so outputs derived from state are also masked by rst directly.
   assign req_ready     = (state_q == IDLE && !rst) ? grant : '0;
   assign eng_start     = state_q == LAUNCH;
   assign eng_rst_n     = !rst && state_q != FLUSH;
   assign rsp_valid     = state_q == RESP;
   assign busy          = state_q != IDLE;
   assign rsp_id        = id_q;
   assign rsp_result    = res_q;
   assign eng_operand_a = opa_q;
   assign eng_operand_b = opb_q;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      id_d    = id_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      res_d   = res_q;
      flush_d = flush_q;
`ifdef MUL_SCHED_TIMEOUT_EN
      cnt_d   = cnt_q;
      err_d   = err_q;
`endif
      case (state_q)
         IDLE: if (|grant) begin
            ptr_d   = (gidx == IDW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
            id_d    = gidx;
            opa_d   = req_a[int'(gidx)*BIT_WIDTH +: BIT_WIDTH];
            opb_d   = req_b[int'(gidx)*BIT_WIDTH +: BIT_WIDTH];
            state_d = LAUNCH;
         end
         LAUNCH: begin
            state_d = WAIT;
`ifdef MUL_SCHED_TIMEOUT_EN
            cnt_d   = '0;
`endif
         end
         WAIT: if (eng_done) begin
            res_d   = eng_result;
`ifdef MUL_SCHED_TIMEOUT_EN
            err_d   = 1'b0;
`endif
            state_d = RESP;
         end
`ifdef MUL_SCHED_TIMEOUT_EN
         else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            res_d   = '0;
            err_d   = 1'b1;
            state_d = RESP;
         end else begin
            cnt_d   = cnt_q + 1'b1;
         end
`endif
         RESP: if (rsp_ready) begin
            flush_d = 1'b0;
            state_d = FLUSH;
         end
         FLUSH: begin
            flush_d = 1'b1;
            state_d = flush_q ? RECOVER : FLUSH;
         end
         RECOVER: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         id_q    <= '0;
         opa_q   <= '0;
         opb_q   <= '0;
         res_q   <= '0;
         flush_q <= 1'b0;
`ifdef MUL_SCHED_TIMEOUT_EN
         cnt_q   <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         id_q    <= id_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         res_q   <= res_d;
         flush_q <= flush_d;
`ifdef MUL_SCHED_TIMEOUT_EN
         cnt_q   <= cnt_d;
         err_q   <= err_d;
`endif
      end
   end

endmodule
